control_sequencer: RTL and testbench

//  Hardwired Moore control unit for the single-bus datapath. Steps through fetch (T0-T2) and a
//  per-opcode execute sequence (T3-T7), one step per clock. Drives every datapath control strobe

---
 rtl/control_sequencer_pkg.sv | 33 +++
 rtl/control_sequencer_if.sv | 27 ++
 rtl/control_sequencer_op_decoder.sv | 28 ++
 rtl/control_sequencer.sv | 112 +++++++++++
 tb/tb_control_sequencer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - shared cpu_defs package: opcodes, ALU codes, step and class enums
package cpu_defs;

  localparam int OPC_W   = 5;
  localparam int ALUOP_W = 4;

  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_AND = 4'd0, ALU_OR  = 4'd1, ALU_ADD = 4'd2,  ALU_SUB = 4'd3,
    ALU_MUL = 4'd4, ALU_DIV = 4'd5, ALU_SHR = 4'd6,  ALU_SHL = 4'd7,
    ALU_ROR = 4'd8, ALU_ROL = 4'd9, ALU_NEG = 4'd10, ALU_NOT = 4'd11
  } alu_op_e;

  typedef enum logic [3:0] {
    ST_RST = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T2 = 4'd3, ST_T3 = 4'd4,
    ST_T4  = 4'd5, ST_T5 = 4'd6, ST_T6 = 4'd7, ST_T7 = 4'd8, ST_HALT = 4'd9
  } step_e;

  typedef enum logic [2:0] {
    CLS_LD, CLS_LDI, CLS_ST, CLS_ALU3, CLS_ALUI, CLS_NOP, CLS_HALT, CLS_BAD
  } instr_class_e;

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - control-unit to datapath strobe bundle
interface control_sequencer_if;
  import cpu_defs::*;

  logic [31:0]        ir;
  logic               stop;
  logic               pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in;
  logic               y_in, z_in, z_low_out, c_out;
  logic               gra, grb, grc, r_in, r_out, ba_out;
  logic               read, write;
  logic [ALUOP_W-1:0] alu_op;
  logic               run, illegal_op;

  modport master (
    input  ir, stop,
    output pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in,
           y_in, z_in, z_low_out, c_out, gra, grb, grc, r_in, r_out, ba_out,
           read, write, alu_op, run, illegal_op
  );

  modport slave (
    output ir, stop,
    input  pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in,
           y_in, z_in, z_low_out, c_out, gra, grb, grc, r_in, r_out, ba_out,
           read, write, alu_op, run, illegal_op
  );
endinterface

// File: rtl/control_sequencer_op_decoder.sv
// rtl/control_sequencer_op_decoder.sv - opcode to instruction class and ALU function
module op_decoder
  import cpu_defs::*;
(
  input  logic [OPC_W-1:0] opcode,
  output instr_class_e     cls,
  output alu_op_e          alu_fn
);

  always_comb begin
    cls    = CLS_BAD;
    alu_fn = ALU_ADD;
    case (opcode)
      OPC_LD:   cls = CLS_LD;
      OPC_LDI:  cls = CLS_LDI;
      OPC_ST:   cls = CLS_ST;
      OPC_ADD:  begin cls = CLS_ALU3; alu_fn = ALU_ADD; end
      OPC_SUB:  begin cls = CLS_ALU3; alu_fn = ALU_SUB; end
      OPC_AND:  begin cls = CLS_ALU3; alu_fn = ALU_AND; end
      OPC_OR:   begin cls = CLS_ALU3; alu_fn = ALU_OR;  end
      OPC_ADDI: cls = CLS_ALUI;
      OPC_NOP:  cls = CLS_NOP;
      OPC_HALT: cls = CLS_HALT;
      default:  cls = CLS_BAD;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Moore control unit: fetch T0-T2, per-opcode execute T3-T7
module control_sequencer
  import cpu_defs::*;
(
  input  logic                clk,
  input  logic                reset_n,
  control_sequencer_if.master bus
);

  step_e        step, step_nxt;
  logic         stop_pend, stop_pend_nxt;
  logic         last;
  instr_class_e cls;
  alu_op_e      alu_fn;

  op_decoder u_dec (
    .opcode (bus.ir[31:27]),
    .cls    (cls),
    .alu_fn (alu_fn)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step      <= ST_RST;
      stop_pend <= 1'b0;
    end else begin
      step      <= step_nxt;
      stop_pend <= stop_pend_nxt;
    end
  end

  always_comb begin
    last = 1'b0;
    case (cls)
      CLS_LD, CLS_ST:               last = (step == ST_T7);
      CLS_LDI, CLS_ALU3, CLS_ALUI:  last = (step == ST_T5);
      default:                      last = (step == ST_T3);
    endcase
  end

  // A stop request seen anywhere in an instruction is held until its boundary.
  always_comb begin
    step_nxt      = step;
    stop_pend_nxt = stop_pend | bus.stop;
    case (step)
      ST_RST:  begin step_nxt = ST_T0; stop_pend_nxt = 1'b0; end
      ST_HALT: begin step_nxt = ST_HALT; stop_pend_nxt = 1'b0; end
      ST_T2:   step_nxt = (cls == CLS_HALT) ? ST_HALT : ST_T3;
      default: begin
        if (last) begin
          step_nxt      = (bus.stop || stop_pend) ? ST_HALT : ST_T0;
          stop_pend_nxt = 1'b0;
        end else begin
          step_nxt = step_e'(step + 4'd1);
        end
      end
    endcase
  end

  always_comb begin
    {bus.pc_out, bus.pc_in, bus.inc_pc, bus.mar_in, bus.mdr_in, bus.mdr_out, bus.ir_in} = '0;
    {bus.y_in, bus.z_in, bus.z_low_out, bus.c_out} = '0;
    {bus.gra, bus.grb, bus.grc, bus.r_in, bus.r_out, bus.ba_out} = '0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.alu_op     = ALU_AND;
    bus.illegal_op = 1'b0;
    bus.run        = (step != ST_RST) && (step != ST_HALT);
    case (step)
      ST_T0: begin
        bus.pc_out = 1'b1; bus.mar_in = 1'b1; bus.inc_pc = 1'b1; bus.z_in = 1'b1;
        bus.alu_op = ALU_ADD;
      end
      ST_T1: begin
        bus.z_low_out = 1'b1; bus.pc_in = 1'b1; bus.read = 1'b1; bus.mdr_in = 1'b1;
      end
      ST_T2: begin bus.mdr_out = 1'b1; bus.ir_in = 1'b1; end
      ST_T3: begin
        case (cls)
          CLS_LD, CLS_LDI, CLS_ST: begin bus.grb = 1'b1; bus.ba_out = 1'b1; bus.y_in = 1'b1; end
          CLS_ALU3, CLS_ALUI:      begin bus.grb = 1'b1; bus.r_out = 1'b1; bus.y_in = 1'b1; end
          CLS_BAD:                 bus.illegal_op = 1'b1;
          default: ;
        endcase
      end
      ST_T4: begin
        bus.z_in = 1'b1;
        if (cls == CLS_ALU3) begin
          bus.grc = 1'b1; bus.r_out = 1'b1; bus.alu_op = alu_fn;
        end else begin
          bus.c_out = 1'b1; bus.alu_op = ALU_ADD;
        end
      end
      ST_T5: begin
        bus.z_low_out = 1'b1;
        if (cls == CLS_LD || cls == CLS_ST) bus.mar_in = 1'b1;
        else begin bus.gra = 1'b1; bus.r_in = 1'b1; end
      end
      ST_T6: begin
        bus.mdr_in = 1'b1;
        if (cls == CLS_LD) bus.read = 1'b1;
        else begin bus.gra = 1'b1; bus.r_out = 1'b1; end
      end
      ST_T7: begin
        if (cls == CLS_LD) begin bus.mdr_out = 1'b1; bus.gra = 1'b1; bus.r_in = 1'b1; end
        else bus.write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench with per-instruction reference sequences
module tb_control_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  localparam logic [24:0] PC_OUT = 25'd1 << 24, PC_IN  = 25'd1 << 23, INC_PC = 25'd1 << 22;
  localparam logic [24:0] MAR_IN = 25'd1 << 21, MDR_IN = 25'd1 << 20, MDR_OUT = 25'd1 << 19;
  localparam logic [24:0] IR_IN  = 25'd1 << 18, Y_IN   = 25'd1 << 17, Z_IN   = 25'd1 << 16;
  localparam logic [24:0] Z_LOW  = 25'd1 << 15, C_OUT  = 25'd1 << 14, GRA    = 25'd1 << 13;
  localparam logic [24:0] GRB    = 25'd1 << 12, GRC    = 25'd1 << 11, R_IN   = 25'd1 << 10;
  localparam logic [24:0] R_OUT  = 25'd1 << 9,  BA_OUT = 25'd1 << 8,  RD     = 25'd1 << 7;
  localparam logic [24:0] WR     = 25'd1 << 6,  RUN    = 25'd1 << 1,  ILL    = 25'd1;
  localparam logic [24:0] F_ADD  = 25'd2 << 2,  F_SUB  = 25'd3 << 2,  F_OR   = 25'd1 << 2;
  localparam int HALT_CYC = 20;

  logic [24:0] exp_q[$];
  string       tag_q[$];
  logic [24:0] seq[$];
  bit          seq_halt;
  logic [24:0] m_exp, m_got;
  string       m_tag;

  function automatic logic [24:0] observe();
    return {bus.pc_out, bus.pc_in, bus.inc_pc, bus.mar_in, bus.mdr_in, bus.mdr_out, bus.ir_in,
            bus.y_in, bus.z_in, bus.z_low_out, bus.c_out, bus.gra, bus.grb, bus.grc,
            bus.r_in, bus.r_out, bus.ba_out, bus.read, bus.write, bus.alu_op, bus.run,
            bus.illegal_op};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_tag = tag_q.pop_front();
      m_got = observe();
      total++;
      if (m_got !== m_exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", m_tag, m_got, m_exp);
      end
      total++;
      if (bus.read && bus.write) begin
        bad++;
        $display("FAIL %s rd_wr_excl: got read=1 write=1 want not both", m_tag);
      end
    end
  end

  // Reference: fetch then the execute list for the opcode, every step with run set.
  task automatic model_seq(input logic [31:0] instr);
    logic [4:0]  opc;
    logic [24:0] ex[$];
    opc = instr[31:27];
    seq.delete();
    seq_halt = 1'b0;
    seq.push_back(PC_OUT | MAR_IN | INC_PC | Z_IN | F_ADD);
    seq.push_back(Z_LOW | PC_IN | RD | MDR_IN);
    seq.push_back(MDR_OUT | IR_IN);
    case (opc)
      5'b00000: ex = '{GRB | BA_OUT | Y_IN, C_OUT | Z_IN | F_ADD, Z_LOW | MAR_IN,
                       RD | MDR_IN, MDR_OUT | GRA | R_IN};
      5'b00001: ex = '{GRB | BA_OUT | Y_IN, C_OUT | Z_IN | F_ADD, Z_LOW | GRA | R_IN};
      5'b00010: ex = '{GRB | BA_OUT | Y_IN, C_OUT | Z_IN | F_ADD, Z_LOW | MAR_IN,
                       GRA | R_OUT | MDR_IN, WR};
      5'b00011: ex = '{GRB | R_OUT | Y_IN, GRC | R_OUT | Z_IN | F_ADD, Z_LOW | GRA | R_IN};
      5'b00100: ex = '{GRB | R_OUT | Y_IN, GRC | R_OUT | Z_IN | F_SUB, Z_LOW | GRA | R_IN};
      5'b00101: ex = '{GRB | R_OUT | Y_IN, GRC | R_OUT | Z_IN, Z_LOW | GRA | R_IN};
      5'b00110: ex = '{GRB | R_OUT | Y_IN, GRC | R_OUT | Z_IN | F_OR, Z_LOW | GRA | R_IN};
      5'b01100: ex = '{GRB | R_OUT | Y_IN, C_OUT | Z_IN | F_ADD, Z_LOW | GRA | R_IN};
      5'b11010: ex = '{25'd0};
      5'b11011: seq_halt = 1'b1;
      default:  ex = '{ILL};
    endcase
    foreach (ex[i]) seq.push_back(ex[i]);
    foreach (seq[i]) seq[i] = seq[i] | RUN;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [24:0] v, input string t);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic check(input string t, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", t, got, want);
    end
  endtask

  task automatic do_reset(input int n, input string t);
    reset_n  = 1'b0;
    bus.stop = 1'b0;
    for (int i = 0; i < n; i++) begin
      push(25'd0, {t, "/rst"});
      tick();
    end
    reset_n = 1'b1;
    push(25'd0, {t, "/rst_rel"});
    tick();
  endtask

  // Entered in the T0 window; returns in the next T0 window.
  task automatic run_instr(input logic [31:0] instr, input int stop_at, input string t);
    int n;
    bit halted;
    bus.ir = instr;
    model_seq(instr);
    n = seq.size();
    halted = seq_halt || (stop_at >= 0 && stop_at < n);
    foreach (seq[i]) push(seq[i], t);
    for (int i = 0; i < n; i++) begin
      bus.stop = (i == stop_at);
      tick();
    end
    bus.stop = 1'b0;
    if (halted) begin
      for (int i = 0; i < HALT_CYC; i++) begin
        push(25'd0, {t, "/halt"});
        bus.stop = 1'($urandom_range(0, 1));
        tick();
      end
      bus.stop = 1'b0;
      do_reset(1 + $urandom_range(0, 1), t);
    end
  endtask

  logic [4:0]  legal_opc[9] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                                5'b00101, 5'b00110, 5'b01100, 5'b11010};
  logic [31:0] rnd_ir;
  int          rnd_stop;

  initial begin
    bus.ir   = 32'h0;
    bus.stop = 1'b0;
    tick();
    do_reset(2, "reset");

    run_instr(32'h00800085, -1, "ld");
    run_instr(32'h19890000, -1, "add");
    run_instr(32'h11000090, -1, "st");
    run_instr(32'hD8000000, -1, "halt");

    bus.ir = 32'h00800085;
    model_seq(32'h00800085);
    for (int i = 0; i < 5; i++) push(seq[i], "ld_pre_rst");
    for (int i = 0; i < 5; i++) tick();
    #1;
    reset_n = 1'b0;
    push(25'd0, "ld_mid_rst");
    #1;
    check("mid_rst_async", {29'd0, bus.read, bus.write, bus.run}, 32'd0);
    tick();
    push(25'd0, "ld_mid_rst_hold");
    tick();
    reset_n = 1'b1;
    push(25'd0, "ld_mid_rst_rel");
    tick();
    run_instr(32'h00800085, -1, "ld_after_rst");

    run_instr(32'h60880005, 4, "addi_stop");
    run_instr(32'hF8000000, -1, "illegal");
    run_instr(32'h08400011, -1, "ldi");

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) rnd_ir = $urandom;
      else rnd_ir = {legal_opc[$urandom_range(0, 8)], 27'($urandom)};
      rnd_stop = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1;
      run_instr(rnd_ir, rnd_stop, $sformatf("rnd%0d_%h", k, rnd_ir));
    end

    tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
